// File: rtl/hart_pkg.sv
// Shared definitions for the single-cycle RV32I hart.
// Holds the opcode and funct3 encodings, the EBREAK word, the ALU operation
// enum and the ALU helper functions used by the datapath in hart.sv.
package hart_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Register / immediate arithmetic funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] EBREAK_WORD = 32'h00100073;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Map funct3 to an ALU op; alt_sub selects SUB for funct3=000 (OP only),
    // alt_sra selects SRA for funct3=101.
    function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                           input logic alt_sub,
                                           input logic alt_sra);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt_sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt_sra ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // 32-bit ALU; shift amounts use only the low five bits of b.
    function automatic logic [31:0] alu_calc(input alu_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'd0, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hart_rf.sv
// 32 x 32-bit integer register file for the hart.
// Two combinational read ports, one write port committed on the rising edge,
// asynchronous active-low clear of every register. x0 always reads zero and
// writes to it are dropped.
// Ports: clk, rst_n, rs1_addr/rs1_data, rs2_addr/rs2_data,
//        wr_en, wr_addr, wr_data.
module hart_rf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_r [32];

    // Register storage: async clear, synchronous write (x0 never written)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0000_0000 : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0000_0000 : regs_r[rs2_addr];

endmodule

// File: rtl/hart.sv
// Single-cycle RV32I hart. Fetch, decode, execute, memory access and retire
// reporting are all combinational within one clock; PC, register file and
// the sticky halted flag commit on the rising edge of i_clk.
// Ports:
//   i_clk, i_rst (async, active-low)
//   o_imem_raddr / i_imem_rdata          instruction fetch
//   o_dmem_addr, o_dmem_ren, o_dmem_wen,
//   o_dmem_wdata, o_dmem_mask, i_dmem_rdata  word-aligned data port
//   o_retire_*                            per-instruction architectural effects
// Configuration macro: HART_TRAP_EN enables illegal-instruction and
// misalignment traps; without it the trap output is tied low, illegal
// encodings are no-ops and misaligned accesses use the aligned lane.
module hart
    import hart_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_retire_valid,
    output logic [31:0] o_retire_inst,
    output logic        o_retire_trap,
    output logic        o_retire_halt,
    output logic [4:0]  o_retire_rs1_raddr,
    output logic [4:0]  o_retire_rs2_raddr,
    output logic [31:0] o_retire_rs1_rdata,
    output logic [31:0] o_retire_rs2_rdata,
    output logic [4:0]  o_retire_rd_waddr,
    output logic [31:0] o_retire_rd_wdata,
    output logic [31:0] o_retire_pc,
    output logic [31:0] o_retire_next_pc
);

    logic [31:0] pc_r;
    logic        halted_r;

    logic [31:0] inst_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_rdata_s, rs2_rdata_s;

    logic        legal_s, use_rs1_s, use_rs2_s, rd_wr_s;
    logic        is_load_s, is_store_s, is_branch_s, is_jump_s, is_ebreak_s;
    logic        alu_b_imm_s;
    alu_op_e     alu_op_s;
    logic [31:0] alu_res_s;

    logic        br_cond_s, taken_s;
    logic [31:0] pc_plus4_s, target_s, next_pc_s;

    logic [31:0] ea_s;
    logic [1:0]  lane_off_s;
    logic        mem_misal_s, tgt_misal_s, trap_s;
    logic [31:0] load_shift_s, load_data_s, store_data_s;
    logic [3:0]  store_mask_s;
    logic [31:0] rd_wdata_s;

    logic        active_s, exec_s, halt_now_s, rd_we_s;

    assign inst_s   = i_imem_rdata;
    assign opcode_s = inst_s[6:0];
    assign rd_s     = inst_s[11:7];
    assign funct3_s = inst_s[14:12];
    assign rs1_s    = inst_s[19:15];
    assign rs2_s    = inst_s[24:20];
    assign funct7_s = inst_s[31:25];

    assign imm_i_s = {{20{inst_s[31]}}, inst_s[31:20]};
    assign imm_s_s = {{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
    assign imm_b_s = {{19{inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
    assign imm_u_s = {inst_s[31:12], 12'h000};
    assign imm_j_s = {{11{inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};

    hart_rf u_rf (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .rs1_addr (rs1_s),
        .rs1_data (rs1_rdata_s),
        .rs2_addr (rs2_s),
        .rs2_data (rs2_rdata_s),
        .wr_en    (rd_we_s),
        .wr_addr  (rd_s),
        .wr_data  (rd_wdata_s)
    );

    // Instruction decode: legality, operand usage and instruction class
    always_comb begin
        legal_s     = 1'b0;
        use_rs1_s   = 1'b0;
        use_rs2_s   = 1'b0;
        rd_wr_s     = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        is_jump_s   = 1'b0;
        is_ebreak_s = 1'b0;
        alu_b_imm_s = 1'b0;
        alu_op_s    = ALU_ADD;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                legal_s = 1'b1;
                rd_wr_s = 1'b1;
            end
            OPC_JAL: begin
                legal_s   = 1'b1;
                rd_wr_s   = 1'b1;
                is_jump_s = 1'b1;
            end
            OPC_JALR: begin
                legal_s   = (funct3_s == 3'b000);
                use_rs1_s = 1'b1;
                rd_wr_s   = 1'b1;
                is_jump_s = 1'b1;
            end
            OPC_BRANCH: begin
                legal_s     = (funct3_s != 3'b010) && (funct3_s != 3'b011);
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                is_branch_s = 1'b1;
            end
            OPC_LOAD: begin
                legal_s   = (funct3_s == F3_LB) || (funct3_s == F3_LH) || (funct3_s == F3_LW) ||
                            (funct3_s == F3_LBU) || (funct3_s == F3_LHU);
                use_rs1_s = 1'b1;
                rd_wr_s   = 1'b1;
                is_load_s = 1'b1;
            end
            OPC_STORE: begin
                legal_s    = (funct3_s == F3_SB) || (funct3_s == F3_SH) || (funct3_s == F3_SW);
                use_rs1_s  = 1'b1;
                use_rs2_s  = 1'b1;
                is_store_s = 1'b1;
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    F3_SLL:  legal_s = (funct7_s == F7_BASE);
                    F3_SR:   legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                    default: legal_s = 1'b1;
                endcase
                use_rs1_s   = 1'b1;
                rd_wr_s     = 1'b1;
                alu_b_imm_s = 1'b1;
                alu_op_s    = alu_decode(funct3_s, 1'b0, funct7_s[5]);
            end
            OPC_OP: begin
                legal_s   = (funct7_s == F7_BASE) ||
                            ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR)));
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                rd_wr_s   = 1'b1;
                alu_op_s  = alu_decode(funct3_s, funct7_s[5], funct7_s[5]);
            end
            OPC_MISC_MEM: begin
                // FENCE retires as a no-op
                legal_s = (funct3_s == 3'b000);
            end
            OPC_SYSTEM: begin
                // Only EBREAK is implemented; anything else is illegal
                legal_s     = (inst_s == EBREAK_WORD);
                is_ebreak_s = (inst_s == EBREAK_WORD);
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign alu_res_s = alu_calc(alu_op_s, rs1_rdata_s, alu_b_imm_s ? imm_i_s : rs2_rdata_s);

    // Branch condition evaluation
    always_comb begin
        br_cond_s = 1'b0;
        case (funct3_s)
            F3_BEQ:  br_cond_s = (rs1_rdata_s == rs2_rdata_s);
            F3_BNE:  br_cond_s = (rs1_rdata_s != rs2_rdata_s);
            F3_BLT:  br_cond_s = ($signed(rs1_rdata_s) <  $signed(rs2_rdata_s));
            F3_BGE:  br_cond_s = ($signed(rs1_rdata_s) >= $signed(rs2_rdata_s));
            F3_BLTU: br_cond_s = (rs1_rdata_s <  rs2_rdata_s);
            F3_BGEU: br_cond_s = (rs1_rdata_s >= rs2_rdata_s);
            default: br_cond_s = 1'b0;
        endcase
    end

    assign pc_plus4_s = pc_r + 32'd4;
    assign taken_s    = legal_s && (is_jump_s || (is_branch_s && br_cond_s));

    // Control-flow target selection (JALR clears bit 0)
    always_comb begin
        target_s = pc_r + imm_b_s;
        case (opcode_s)
            OPC_JAL:  target_s = pc_r + imm_j_s;
            OPC_JALR: target_s = (rs1_rdata_s + imm_i_s) & 32'hFFFF_FFFE;
            default:  target_s = pc_r + imm_b_s;
        endcase
    end

    // Effective address and alignment check by access size (funct3[1:0])
    assign ea_s = rs1_rdata_s + (is_store_s ? imm_s_s : imm_i_s);

    always_comb begin
        mem_misal_s = 1'b0;
        case (funct3_s[1:0])
            2'b00:   mem_misal_s = 1'b0;
            2'b01:   mem_misal_s = ea_s[0];
            default: mem_misal_s = (ea_s[1:0] != 2'b00);
        endcase
        if (!(legal_s && (is_load_s || is_store_s))) begin
            mem_misal_s = 1'b0;
        end else begin
            mem_misal_s = mem_misal_s;
        end
    end

    assign tgt_misal_s = taken_s && (target_s[1:0] != 2'b00);

`ifdef HART_TRAP_EN
    assign trap_s     = !legal_s || mem_misal_s || tgt_misal_s;
    assign lane_off_s = ea_s[1:0];
`else
    // Misaligned accesses fall back to the lowest lane of the word
    assign trap_s     = 1'b0;
    assign lane_off_s = mem_misal_s ? 2'b00 : ea_s[1:0];
`endif

    assign active_s   = i_rst && !halted_r;
    assign exec_s     = active_s && legal_s && !trap_s;
    assign halt_now_s = is_ebreak_s || trap_s;

    // A halting instruction leaves the PC where it is
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (halt_now_s) begin
            next_pc_s = pc_r;
        end else if (taken_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Load lane extraction and sign/zero extension
    assign load_shift_s = i_dmem_rdata >> {lane_off_s, 3'b000};

    always_comb begin
        load_data_s = load_shift_s;
        case (funct3_s)
            F3_LB:   load_data_s = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
            F3_LH:   load_data_s = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
            F3_LW:   load_data_s = load_shift_s;
            F3_LBU:  load_data_s = {24'h000000, load_shift_s[7:0]};
            F3_LHU:  load_data_s = {16'h0000, load_shift_s[15:0]};
            default: load_data_s = load_shift_s;
        endcase
    end

    // Store lane placement and byte-enable mask
    assign store_data_s = rs2_rdata_s << {lane_off_s, 3'b000};

    always_comb begin
        store_mask_s = 4'b1111;
        case (funct3_s[1:0])
            2'b00:   store_mask_s = 4'b0001 << lane_off_s;
            2'b01:   store_mask_s = 4'b0011 << lane_off_s;
            default: store_mask_s = 4'b1111;
        endcase
    end

    // Destination register write-back value
    always_comb begin
        rd_wdata_s = alu_res_s;
        case (opcode_s)
            OPC_LUI:            rd_wdata_s = imm_u_s;
            OPC_AUIPC:          rd_wdata_s = pc_r + imm_u_s;
            OPC_JAL, OPC_JALR:  rd_wdata_s = pc_plus4_s;
            OPC_LOAD:           rd_wdata_s = load_data_s;
            default:            rd_wdata_s = alu_res_s;
        endcase
    end

    assign rd_we_s = exec_s && rd_wr_s && (rd_s != 5'd0);

    // PC and sticky halted flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_r     <= RESET_ADDR;
            halted_r <= 1'b0;
        end else if (active_s) begin
            pc_r <= next_pc_s;
            if (halt_now_s) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= 1'b0;
            end
        end else begin
            pc_r     <= pc_r;
            halted_r <= halted_r;
        end
    end

    assign o_imem_raddr = pc_r;

    assign o_dmem_addr  = {ea_s[31:2], 2'b00};
    assign o_dmem_ren   = exec_s && is_load_s;
    assign o_dmem_wen   = exec_s && is_store_s;
    assign o_dmem_wdata = store_data_s;
    assign o_dmem_mask  = o_dmem_wen ? store_mask_s : 4'b0000;

    assign o_retire_valid     = active_s;
    assign o_retire_inst      = inst_s;
    assign o_retire_trap      = active_s && trap_s;
    assign o_retire_halt      = i_rst && (halted_r || halt_now_s);
    assign o_retire_rs1_raddr = use_rs1_s ? rs1_s : 5'd0;
    assign o_retire_rs2_raddr = use_rs2_s ? rs2_s : 5'd0;
    assign o_retire_rs1_rdata = use_rs1_s ? rs1_rdata_s : 32'h0000_0000;
    assign o_retire_rs2_rdata = use_rs2_s ? rs2_rdata_s : 32'h0000_0000;
    assign o_retire_rd_waddr  = rd_we_s ? rd_s : 5'd0;
    assign o_retire_rd_wdata  = rd_we_s ? rd_wdata_s : 32'h0000_0000;
    assign o_retire_pc        = pc_r;
    assign o_retire_next_pc   = next_pc_s;

endmodule

// File: tb/tb_hart.sv
// Directed testbench for the single-cycle RV32I hart: a small program in a
// bench-owned instruction memory, a byte-enabled data memory model, and
// hand-computed retire values checked once per retired instruction.
module tb_hart;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_ren;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic [31:0] i_dmem_rdata;
    logic        o_retire_valid;
    logic [31:0] o_retire_inst;
    logic        o_retire_trap;
    logic        o_retire_halt;
    logic [4:0]  o_retire_rs1_raddr;
    logic [4:0]  o_retire_rs2_raddr;
    logic [31:0] o_retire_rs1_rdata;
    logic [31:0] o_retire_rs2_rdata;
    logic [4:0]  o_retire_rd_waddr;
    logic [31:0] o_retire_rd_wdata;
    logic [31:0] o_retire_pc;
    logic [31:0] o_retire_next_pc;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    int checks_cnt = 0;
    int fail_cnt   = 0;

    hart #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .o_imem_raddr       (o_imem_raddr),
        .i_imem_rdata       (i_imem_rdata),
        .o_dmem_addr        (o_dmem_addr),
        .o_dmem_ren         (o_dmem_ren),
        .o_dmem_wen         (o_dmem_wen),
        .o_dmem_wdata       (o_dmem_wdata),
        .o_dmem_mask        (o_dmem_mask),
        .i_dmem_rdata       (i_dmem_rdata),
        .o_retire_valid     (o_retire_valid),
        .o_retire_inst      (o_retire_inst),
        .o_retire_trap      (o_retire_trap),
        .o_retire_halt      (o_retire_halt),
        .o_retire_rs1_raddr (o_retire_rs1_raddr),
        .o_retire_rs2_raddr (o_retire_rs2_raddr),
        .o_retire_rs1_rdata (o_retire_rs1_rdata),
        .o_retire_rs2_rdata (o_retire_rs2_rdata),
        .o_retire_rd_waddr  (o_retire_rd_waddr),
        .o_retire_rd_wdata  (o_retire_rd_wdata),
        .o_retire_pc        (o_retire_pc),
        .o_retire_next_pc   (o_retire_next_pc)
    );

    assign i_imem_rdata = imem[o_imem_raddr[9:2]];
    assign i_dmem_rdata = dmem[o_dmem_addr[9:2]];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Data memory write with byte enables
    always @(posedge i_clk) begin
        if (o_dmem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (o_dmem_mask[b]) dmem[o_dmem_addr[9:2]][8*b +: 8] <= o_dmem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next retired instruction, sampling away from the rising edge
    task automatic next_retire();
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'h0000_0000;
        end
        imem[0]   = 32'h0010_0093; // addi x1,x0,1
        imem[1]   = 32'h0010_0113; // addi x2,x0,1
        imem[2]   = 32'h0020_8f33; // add  x30,x1,x2
        imem[3]   = 32'h0020_0e93; // addi x29,x0,2
        imem[4]   = 32'h1ddf_1e63; // bne  x30,x29,+0x1dc
        imem[5]   = 32'h0030_0093; // addi x1,x0,3
        imem[6]   = 32'h0070_0113; // addi x2,x0,7
        imem[7]   = 32'h0020_8f33; // add  x30,x1,x2
        imem[8]   = 32'h00a0_0e93; // addi x29,x0,10
        imem[9]   = 32'h1ddf_1e63; // bne  (not taken)
        imem[10]  = 32'h0090_0e93; // addi x29,x0,9
        imem[11]  = 32'h1ddf_1e63; // bne  (taken -> 0x208)
        imem[130] = 32'h0ab0_0293; // 0x208 addi x5,x0,0xab
        imem[131] = 32'h1020_0313; // 0x20c addi x6,x0,0x102
        imem[132] = 32'h0053_0023; // 0x210 sb   x5,0(x6)
        imem[133] = 32'h0003_0383; // 0x214 lb   x7,0(x6)
        imem[134] = 32'h0003_4403; // 0x218 lbu  x8,0(x6)
        imem[135] = 32'h4043_d593; // 0x21c srai x11,x7,4
        imem[136] = 32'h0080_00ef; // 0x220 jal  x1,+8
        imem[137] = 32'h0000_0000; // 0x224 skipped
`ifdef HART_TRAP_EN
        imem[138] = 32'hfff3_2603; // 0x228 lw   x12,-1(x6) -> 0x101 misaligned
`else
        imem[138] = 32'h0010_0073; // 0x228 ebreak
`endif

        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_retire_valid}, 32'd0);
        chk("rst_halt",  {31'd0, o_retire_halt},  32'd0);
        chk("rst_pc",    o_imem_raddr,            32'h0000_0000);
        chk("rst_ren",   {31'd0, o_dmem_ren},     32'd0);
        chk("rst_wen",   {31'd0, o_dmem_wen},     32'd0);

        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("i0_valid",   {31'd0, o_retire_valid}, 32'd1);
        chk("i0_pc",      o_retire_pc,             32'h0000_0000);
        chk("i0_next_pc", o_retire_next_pc,        32'h0000_0004);
        chk("i0_rs1",     o_retire_rs1_rdata,      32'h0000_0000);
        chk("i0_rd",      {27'd0, o_retire_rd_waddr}, 32'd1);
        chk("i0_wdata",   o_retire_rd_wdata,       32'h0000_0001);

        next_retire();
        chk("i1_rd",    {27'd0, o_retire_rd_waddr}, 32'd2);
        chk("i1_wdata", o_retire_rd_wdata,          32'h0000_0001);
        next_retire();
        chk("add1_rs1", o_retire_rs1_rdata,          32'h0000_0001);
        chk("add1_rs2", o_retire_rs2_rdata,          32'h0000_0001);
        chk("add1_rd",  {27'd0, o_retire_rd_waddr},  32'd30);
        chk("add1_w",   o_retire_rd_wdata,           32'h0000_0002);
        next_retire();
        chk("x29_2",    o_retire_rd_wdata,           32'h0000_0002);
        next_retire();
        chk("bne1_pc",   o_retire_pc,                32'h0000_0010);
        chk("bne1_next", o_retire_next_pc,           32'h0000_0014);
        chk("bne1_rd",   {27'd0, o_retire_rd_waddr}, 32'd0);
        next_retire();
        next_retire();
        next_retire();
        chk("add2_w",    o_retire_rd_wdata,          32'h0000_000a);
        next_retire();
        chk("x29_10",    o_retire_rd_wdata,          32'h0000_000a);
        next_retire();
        chk("bne2_next", o_retire_next_pc,           32'h0000_0028);
        next_retire();
        chk("x29_9",     o_retire_rd_wdata,          32'h0000_0009);
        next_retire();
        chk("bne3_pc",   o_retire_pc,                32'h0000_002c);
        chk("bne3_next", o_retire_next_pc,           32'h0000_0208);

        next_retire();
        chk("tgt_pc",   o_retire_pc,        32'h0000_0208);
        chk("x5_w",     o_retire_rd_wdata,  32'h0000_00ab);
        next_retire();
        chk("x6_w",     o_retire_rd_wdata,  32'h0000_0102);
        next_retire();
        chk("sb_wen",   {31'd0, o_dmem_wen},        32'd1);
        chk("sb_ren",   {31'd0, o_dmem_ren},        32'd0);
        chk("sb_addr",  o_dmem_addr,                32'h0000_0100);
        chk("sb_mask",  {28'd0, o_dmem_mask},       32'h0000_0004);
        chk("sb_wdata", o_dmem_wdata,               32'h00ab_0000);
        chk("sb_rd",    {27'd0, o_retire_rd_waddr}, 32'd0);
        next_retire();
        chk("lb_ren",   {31'd0, o_dmem_ren},        32'd1);
        chk("lb_addr",  o_dmem_addr,                32'h0000_0100);
        chk("lb_w",     o_retire_rd_wdata,          32'hffff_ffab);
        next_retire();
        chk("lbu_w",    o_retire_rd_wdata,          32'h0000_00ab);
        next_retire();
        chk("srai_w",   o_retire_rd_wdata,          32'hffff_fffa);
        next_retire();
        chk("jal_w",    o_retire_rd_wdata,          32'h0000_0224);
        chk("jal_next", o_retire_next_pc,           32'h0000_0228);

        next_retire();
        chk("h_pc",    o_retire_pc,                32'h0000_0228);
        chk("h_valid", {31'd0, o_retire_valid},    32'd1);
        chk("h_halt",  {31'd0, o_retire_halt},     32'd1);
        chk("h_rd",    {27'd0, o_retire_rd_waddr}, 32'd0);
        chk("h_ren",   {31'd0, o_dmem_ren},        32'd0);
`ifdef HART_TRAP_EN
        chk("h_trap",  {31'd0, o_retire_trap},     32'd1);
`else
        chk("h_trap",  {31'd0, o_retire_trap},     32'd0);
`endif

        for (int k = 0; k < 2; k++) begin
            next_retire();
            chk("post_valid", {31'd0, o_retire_valid},    32'd0);
            chk("post_halt",  {31'd0, o_retire_halt},     32'd1);
            chk("post_pc",    o_imem_raddr,               32'h0000_0228);
            chk("post_wen",   {31'd0, o_dmem_wen},        32'd0);
            chk("post_rd",    {27'd0, o_retire_rd_waddr}, 32'd0);
        end

        // Reset again and read back registers that held nonzero values
        i_rst = 1'b0;
        #1;
        chk("rst2_pc",    o_imem_raddr,            32'h0000_0000);
        chk("rst2_valid", {31'd0, o_retire_valid}, 32'd0);
        chk("rst2_halt",  {31'd0, o_retire_halt},  32'd0);
        imem[0] = 32'h0070_81b3; // add x3,x1,x7
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("rst2_ipc",  o_retire_pc,                32'h0000_0000);
        chk("rst2_rs1",  o_retire_rs1_rdata,         32'h0000_0000);
        chk("rst2_rs2",  o_retire_rs2_rdata,         32'h0000_0000);
        chk("rst2_rd",   {27'd0, o_retire_rd_waddr}, 32'd3);
        chk("rst2_w",    o_retire_rd_wdata,          32'h0000_0000);
        chk("rst2_next", o_retire_next_pc,           32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
